// File: rtl/btn_pkg.sv
// Shared constants for the push-button input path.
// - Default debounce lengths for hardware and for fast simulation.
// - Board button count and per-button channel indices.
// - A helper that sizes the debounce counter.
package btn_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_HW  = 250000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
    localparam int unsigned NUM_BTNS_BOARD      = 5;

    // Channel indices into the btn_* vectors.
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    // The extra bit leaves headroom so that DEBOUNCE_CYCLES-1 always fits.
    function automatic int unsigned dbc_cnt_width(int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One push-button channel: 2-FF synchronizer, debounce counter, debounced level,
// registered press/release pulses and a wrapping press counter.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   btn_raw_i      - raw asynchronous button level
//   level_o        - debounced level
//   press_o        - 1-cycle pulse on debounced 0->1
//   release_o      - 1-cycle pulse on debounced 1->0
//   press_set_o    - next-state of press_o, lets the parent register an OR in step
//   press_cnt_o    - wrapping count of presses
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_raw_i,
    output logic             level_o,
    output logic             press_o,
    output logic             release_o,
    output logic             press_set_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int unsigned    DbcW   = dbc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DbcW-1:0] DbcMax = DbcW'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [DbcW-1:0]  dbc_q, dbc_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    always_comb begin
        dbc_d       = dbc_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        press_cnt_d = press_cnt_q;
        if (sync2_q == level_q) begin
            // Any return to agreement restarts the qualification window.
            dbc_d = '0;
        end else if (dbc_q == DbcMax) begin
            dbc_d     = '0;
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
            if (sync2_q) begin
                press_cnt_d = press_cnt_q + CNT_W'(1);
            end
        end else begin
            dbc_d = dbc_q + DbcW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dbc_q       <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sync1_q     <= btn_raw_i;
            sync2_q     <= sync1_q;
            dbc_q       <= dbc_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign press_set_o = press_d;
    assign press_cnt_o = press_cnt_q;

endmodule

// File: rtl/btn_input_conditioner.sv
// Conditions raw push-button levels into clean clk-domain signals for the core
// and top-level control.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   btn_raw       - raw asynchronous button levels, active-high
//   btn_level     - debounced levels
//   btn_press     - 1-cycle pulse per debounced 0->1
//   btn_release   - 1-cycle pulse per debounced 1->0
//   any_press     - registered OR of btn_press, aligned with it
//   press_cnt     - per-button wrapping press counters, button i at [i*CNT_W +: CNT_W]
module btn_input_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = NUM_BTNS_BOARD,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_BTNS-1:0]       btn_raw,
    output logic [NUM_BTNS-1:0]       btn_level,
    output logic [NUM_BTNS-1:0]       btn_press,
    output logic [NUM_BTNS-1:0]       btn_release,
    output logic                      any_press,
    output logic [NUM_BTNS*CNT_W-1:0] press_cnt
);

    logic [NUM_BTNS-1:0] press_set;
    logic                any_press_q;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk_i      (clk),
            .rst_ni     (reset_n),
            .btn_raw_i  (btn_raw[g]),
            .level_o    (btn_level[g]),
            .press_o    (btn_press[g]),
            .release_o  (btn_release[g]),
            .press_set_o(press_set[g]),
            .press_cnt_o(press_cnt[g*CNT_W +: CNT_W])
        );
    end

    // Built from the channels' next-state so it rises on the same edge as btn_press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_set;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_input_conditioner.sv
module tb_btn_input_conditioner;
    import btn_pkg::*;

    localparam int unsigned NB = NUM_BTNS_BOARD;
    localparam int unsigned DC = DEBOUNCE_CYCLES_SIM;
    localparam int unsigned CW = 8;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [NB-1:0]    btn_raw = '0;
    logic [NB-1:0]    btn_level, btn_press, btn_release;
    logic             any_press;
    logic [NB*CW-1:0] press_cnt;

    always #5 clk = ~clk;

    btn_input_conditioner #(
        .NUM_BTNS       (NB),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press),
        .press_cnt  (press_cnt)
    );

    typedef struct {
        int               ev_edge;
        logic [NB-1:0]    press;
        logic [NB-1:0]    rel;
        logic [NB-1:0]    level;
        logic             any;
        logic [NB*CW-1:0] cnt;
    } ev_t;

    ev_t  evq[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = 0;

    // Stimulus-side model of the state that follows each expected event.
    logic [NB-1:0] m_level = '0;
    logic [CW-1:0] m_cnt[NB];

    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int e, input logic [NB-1:0] p, input logic [NB-1:0] r);
        ev_t ev;
        m_level = (m_level | p) & ~r;
        for (int i = 0; i < NB; i++) begin
            if (p[i]) m_cnt[i] = m_cnt[i] + 8'd1;
        end
        ev.ev_edge = e;
        ev.press   = p;
        ev.rel     = r;
        ev.level   = m_level;
        ev.any     = |p;
        for (int i = 0; i < NB; i++) ev.cnt[i*CW +: CW] = m_cnt[i];
        evq.push_back(ev);
    endtask

    // Drive one button cleanly; first sync capture is edge_n+1, level moves DC+1 edges later.
    task automatic toggle_btn(input int b, input logic v);
        logic [NB-1:0] m;
        m = '0;
        m[b] = 1'b1;
        @(negedge clk);
        btn_raw[b] = v;
        push_ev(edge_n + 1 + int'(DC) + 1, v ? m : '0, v ? '0 : m);
        repeat (DC + 2) @(negedge clk);
    endtask

    task automatic model_reset();
        m_level = '0;
        for (int i = 0; i < NB; i++) m_cnt[i] = '0;
    endtask

    // Monitor: pops an expected record whenever the DUT shows a pulse; otherwise
    // checks the quiet outputs against the last expected state.
    initial begin
        logic [NB-1:0]    mon_level;
        logic [NB*CW-1:0] mon_cnt;
        ev_t              e;
        mon_level = '0;
        mon_cnt   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_level = '0;
                mon_cnt   = '0;
            end else if (btn_press != '0 || btn_release != '0) begin
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event edge=%0d press=%b release=%b", edge_n,
                             btn_press, btn_release);
                end else begin
                    e = evq.pop_front();
                    if (e.ev_edge != edge_n || btn_press !== e.press || btn_release !== e.rel ||
                        btn_level !== e.level || any_press !== e.any || press_cnt !== e.cnt) begin
                        bad++;
                        $display("FAIL event: got edge=%0d press=%b rel=%b lvl=%b any=%b cnt=%h want edge=%0d press=%b rel=%b lvl=%b any=%b cnt=%h",
                                 edge_n, btn_press, btn_release, btn_level, any_press, press_cnt,
                                 e.ev_edge, e.press, e.rel, e.level, e.any, e.cnt);
                    end
                    mon_level = e.level;
                    mon_cnt   = e.cnt;
                end
            end else begin
                total++;
                if (evq.size() != 0 && evq[0].ev_edge <= edge_n) begin
                    bad++;
                    $display("FAIL missing_event: edge=%0d got no pulse, want press=%b rel=%b at edge %0d",
                             edge_n, evq[0].press, evq[0].rel, evq[0].ev_edge);
                    mon_level = evq[0].level;
                    mon_cnt   = evq[0].cnt;
                    void'(evq.pop_front());
                end else if (btn_level !== mon_level || press_cnt !== mon_cnt ||
                             any_press !== 1'b0) begin
                    bad++;
                    $display("FAIL idle: edge=%0d got lvl=%b cnt=%h any=%b want lvl=%b cnt=%h any=0",
                             edge_n, btn_level, press_cnt, any_press, mon_level, mon_cnt);
                end
            end
        end
    end

    initial begin
        logic [4:0] bounce;
        model_reset();

        // 1: reset with all buttons held, then all report a press 6 edges after release.
        btn_raw = '1;
        repeat (3) @(negedge clk);
        chk("rst_level", 64'(btn_level), 64'd0);
        chk("rst_press", 64'(btn_press), 64'd0);
        chk("rst_release", 64'(btn_release), 64'd0);
        chk("rst_any", 64'(any_press), 64'd0);
        chk("rst_cnt", 64'(press_cnt), 64'd0);
        reset_n = 1'b1;
        push_ev(edge_n + 6, 5'b11111, 5'b00000);
        repeat (8) @(negedge clk);
        chk("t1_level", 64'(btn_level), 64'h1f);
        for (int i = 0; i < NB; i++) chk("t1_cnt", 64'(press_cnt[i*CW +: CW]), 64'd1);
        @(negedge clk);
        btn_raw = '0;
        push_ev(edge_n + 6, 5'b00000, 5'b11111);
        repeat (8) @(negedge clk);

        // 2: a 3-cycle glitch on btn 0 is rejected.
        @(negedge clk);
        btn_raw[BTN_C] = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw[BTN_C] = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_level", 64'(btn_level[BTN_C]), 64'd0);
        chk("glitch_cnt", 64'(press_cnt[BTN_C*CW +: CW]), 64'd1);

        // 3: clean press and release on btn 2.
        toggle_btn(BTN_L, 1'b1);
        chk("t3_level", 64'(btn_level[BTN_L]), 64'd1);
        toggle_btn(BTN_L, 1'b0);
        chk("t3_cnt", 64'(press_cnt[BTN_L*CW +: CW]), 64'd2);

        // 4: bounce 1,0,1,0,1 on btn 1 gives one press timed from the last rise.
        bounce = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            btn_raw[BTN_U] = bounce[i];
        end
        push_ev(edge_n + 6, 5'b00010, 5'b00000);
        repeat (10) @(negedge clk);
        toggle_btn(BTN_U, 1'b0);

        // 5: btn 4 counter wraps (it starts at 1 after step 1).
        for (int i = 0; i < 254; i++) begin
            toggle_btn(BTN_D, 1'b1);
            toggle_btn(BTN_D, 1'b0);
        end
        chk("wrap_255", 64'(press_cnt[BTN_D*CW +: CW]), 64'd255);
        toggle_btn(BTN_D, 1'b1);
        chk("wrap_0", 64'(press_cnt[BTN_D*CW +: CW]), 64'd0);
        toggle_btn(BTN_D, 1'b0);
        chk("wrap_others", 64'(press_cnt[31:0]), 64'h01020201);

        // 6: asynchronous reset while btn 3 is mid-count, with btn 2 held down.
        toggle_btn(BTN_L, 1'b1);
        @(negedge clk);
        btn_raw[BTN_R] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", 64'(btn_level), 64'd0);
        chk("arst_press", 64'(btn_press), 64'd0);
        chk("arst_release", 64'(btn_release), 64'd0);
        chk("arst_any", 64'(any_press), 64'd0);
        chk("arst_cnt", 64'(press_cnt), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_ev(edge_n + 6, 5'b01100, 5'b00000);
        repeat (8) @(negedge clk);
        chk("t6_level", 64'(btn_level), 64'h0c);
        chk("t6_cnt", 64'(press_cnt), 64'h0001010000);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(evq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_input_conditioner.md
Name: btn_input_conditioner

Overview:
- Input-side counterpart to the LED output path of the board top level.
- Takes raw, asynchronous push-button levels (BTNC/BTNU/BTNL/BTNR/BTND) and delivers a conditioned view to the riscv32 core and top-level control:
  - clean debounced levels,
  - single-cycle press and release pulses,
  - a wrapping press counter per button.
- Sits between the board pins and any consumer in the clk domain, including the core's reset/step logic.

Parameters:
- NUM_BTNS, 5: number of independent button channels; 1..16.
- DEBOUNCE_CYCLES, 250000: consecutive clk cycles a synchronized level must differ from the debounced level before it is accepted; >= 1. The bench uses 4.
- CNT_W, 8: width of each per-button press counter.

Ports:
- clk, input, 1: single clock. All state is on its rising edge.
- reset_n, input, 1: asynchronous active-low reset. Assertion is asynchronous; release is used as-is.
- btn_raw, input, NUM_BTNS: raw asynchronous button levels, active-high.
- btn_level, output, NUM_BTNS: debounced level per button.
- btn_press, output, NUM_BTNS: 1-cycle pulse on a debounced 0->1 transition.
- btn_release, output, NUM_BTNS: 1-cycle pulse on a debounced 1->0 transition.
- any_press, output, 1: OR of btn_press.
- press_cnt, output, NUM_BTNS*CNT_W: per-button press counters. Button i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset:
  - While reset_n=0, all flops clear immediately: sync stages, counters, btn_level, btn_press, btn_release, any_press, press_cnt all 0.
  - Reset mid-debounce discards the partial count.
  - After release, a button held high is reported as a new press once debounced.
- Synchronizer: 2-FF chain per channel (sync1, sync2). Only sync2 is used downstream.
- Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == btn_level: counter <= 0.
  - If sync2 != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= sync2 and counter <= 0.
  - Otherwise: counter <= counter+1.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive edges never changes btn_level. Any return to agreement restarts the count from 0.
- Latency: if btn_raw changes and is first captured by sync1 at edge k, btn_level changes at edge k+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=1, that is edge k+2.
- Pulses:
  - btn_press / btn_release are registered and set at the same edge btn_level changes; high for exactly one cycle.
  - Press and release of the same channel are never simultaneous.
  - Different channels are fully independent; simultaneous events across channels are all reported in the same cycle.
- any_press is registered at the same edge as btn_press (not combinational from btn_press).
- press_cnt[i] increments at the edge btn_press[i] is set. It wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Holding a button does not repeat: no auto-repeat and no further pulses until release is debounced.

Decomposition:
- Package btn_pkg holds:
  - default constants (DEBOUNCE_CYCLES_HW=250000, DEBOUNCE_CYCLES_SIM=4, NUM_BTNS_BOARD=5),
  - button index constants (BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4).
- Sub-module btn_debounce_channel: one channel, containing the synchronizer, counter, level, both pulses and press counter. Parameters DEBOUNCE_CYCLES and CNT_W.
- The top generates NUM_BTNS instances and the any_press OR register.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=8, NUM_BTNS=5):
1. Reset: hold reset_n=0 with btn_raw=5'b11111, then release -> all outputs 0 during reset. After release, btn_level=5'b11111 exactly 6 edges later. btn_press=5'b11111 and any_press=1 for one cycle; each press_cnt=1.
2. Glitch: btn_raw[0] high for 3 cycles, then low -> btn_level[0], btn_press[0] and press_cnt[0] stay 0.
3. Clean press/release: btn_raw[2] rises, captured by sync1 at edge k -> btn_level[2]=1 and btn_press[2]=1 at edge k+5 only. Drop btn_raw[2] -> btn_release[2] is a single-cycle pulse; press_cnt[2]=1.
4. Bounce: btn_raw[1] toggles 1,0,1,0,1 (one cycle each), then stays 1 -> exactly one btn_press[1], 5 edges after the final rising capture.
5. Wrap: 256 clean presses on btn 4 -> press_cnt[4] reads 255 then 0; no other channel changes.
6. Async reset mid-count: assert reset_n=0 between edges while counter=2 -> outputs clear immediately, without waiting for a clk edge. The channel must re-count all 4 cycles after release.
